// File: rtl/serial_frame_collector.sv
// Serial frame receiver: hunts for PATTERN, then deserialises PAYLOAD_W bits into data_out.
// sync_det is zero-latency; data_valid holds the frame until data_ready, and valid bits arriving meanwhile set overrun.
module serial_frame_collector #(
  parameter int               PAT_W     = 7,
  parameter logic [PAT_W-1:0] PATTERN   = 7'b0111110,
  parameter int               PAYLOAD_W = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter int               CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_in,
  input  logic                 in_valid,
  input  logic                 clr,
  input  logic                 data_ready,
  output logic                 sync_det,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 overrun
);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  localparam int HC_W = $clog2(PAT_W);
  localparam int BC_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(PAT_W - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(PAYLOAD_W - 1);

  logic [1:0]           state_q, state_d;
  logic [PAT_W-2:0]     hist_q, hist_d;
  logic [HC_W-1:0]      hist_cnt_q, hist_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 overrun_q, overrun_d;

  // Current bit appended to the history; the full window is what gets compared.
  logic [PAT_W-1:0] window;
  logic             match;

  assign window = {hist_q, ser_in};
  assign match  = in_valid & (hist_cnt_q == HC_MAX) & (window == PATTERN);

  assign sync_det   = match & (state_q == HUNT) & ~clr & ~rst;
  assign data_out   = data_q;
  assign data_valid = data_valid_q;
  assign busy       = (state_q != HUNT);
  assign frame_cnt  = frame_cnt_q;
  assign overrun    = overrun_q;

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    hist_cnt_d   = hist_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
    if (clr) begin
      state_d      = HUNT;
      hist_cnt_d   = '0;
      bit_cnt_d    = '0;
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (in_valid) begin
            hist_d = window[PAT_W-2:0];
            if (hist_cnt_q != HC_MAX) hist_cnt_d = hist_cnt_q + HC_W'(1);
            if (match) begin
              state_d   = COLLECT;
              bit_cnt_d = '0;
            end
          end
        end
        COLLECT: begin
          if (in_valid) begin
            if (MSB_FIRST) data_d = (data_q << 1) | PAYLOAD_W'(ser_in);
            else           data_d = (data_q >> 1) | (PAYLOAD_W'(ser_in) << (PAYLOAD_W - 1));
            if (bit_cnt_q == BC_LAST) begin
              state_d      = HOLD;
              data_valid_d = 1'b1;
              bit_cnt_d    = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BC_W'(1);
            end
          end
        end
        HOLD: begin
          // Bits arriving while the frame is parked are dropped, including in the handshake cycle.
          if (in_valid) overrun_d = 1'b1;
          if (data_ready) begin
            data_valid_d = 1'b0;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            hist_cnt_d   = '0;
            state_d      = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      hist_q       <= '0;
      hist_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      hist_cnt_q   <= hist_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_collector.sv
// Directed bench for serial_frame_collector: default, LSB-first and 2-bit counter instances share one stimulus stream.
module tb_serial_frame_collector;

  logic       clk = 1'b0;
  logic       rst, ser_in, in_valid, clr, data_ready;
  logic       sync_det, data_valid, busy, overrun;
  logic [7:0] data_out, frame_cnt;
  logic       lsb_sync_det, lsb_data_valid, lsb_busy, lsb_overrun;
  logic [7:0] lsb_data_out, lsb_frame_cnt;
  logic       c2_sync_det, c2_data_valid, c2_busy, c2_overrun;
  logic [7:0] c2_data_out;
  logic [1:0] c2_frame_cnt;

  int errors = 0, checks = 0, cyc = 0, sync_cnt = 0, sync_cyc = 0, stray = 0;

  localparam logic [6:0] PAT = 7'b0111110;

  serial_frame_collector dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .in_valid(in_valid), .clr(clr), .data_ready(data_ready),
    .sync_det(sync_det), .data_out(data_out), .data_valid(data_valid), .busy(busy),
    .frame_cnt(frame_cnt), .overrun(overrun));

  serial_frame_collector #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .in_valid(in_valid), .clr(clr), .data_ready(data_ready),
    .sync_det(lsb_sync_det), .data_out(lsb_data_out), .data_valid(lsb_data_valid), .busy(lsb_busy),
    .frame_cnt(lsb_frame_cnt), .overrun(lsb_overrun));

  serial_frame_collector #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .in_valid(in_valid), .clr(clr), .data_ready(data_ready),
    .sync_det(c2_sync_det), .data_out(c2_data_out), .data_valid(c2_data_valid), .busy(c2_busy),
    .frame_cnt(c2_frame_cnt), .overrun(c2_overrun));

  always #5 clk = ~clk;

  // One cycle: inputs change on the falling edge, sync_det is observed 1 ns later.
  task automatic drive4(input logic b, input logic v, input logic rdy, input logic c);
    @(negedge clk);
    ser_in = b; in_valid = v; data_ready = rdy; clr = c;
    #1;
    cyc++;
    if (sync_det) begin
      sync_cnt++;
      sync_cyc = cyc;
      if (!v) stray++;
    end
  endtask

  task automatic drive(input logic b, input logic v);
    drive4(b, v, 1'b1, 1'b0);
  endtask

  task automatic send_seq(input logic [63:0] bits, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      drive(bits[i], 1'b1);
      if (gap) drive(~bits[i], 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] pl);
    send_seq(64'(PAT), 7, 1'b0);
    send_seq(64'(pl), 8, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; ser_in = 1'b0; data_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sync_det !== 1'b0) begin errors++; $display("FAIL reset_sync got %b want 0", sync_det); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", frame_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (c2_frame_cnt !== 2'd0) begin errors++; $display("FAIL reset_c2cnt got %0d want 0", c2_frame_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int s;
    sync_cnt = 0; stray = 0;
    send_seq(64'b110111110, 9, 1'b0);
    checks++; if (sync_cnt !== 1) begin errors++; $display("FAIL basic_sync_cnt got %0d want 1", sync_cnt); end
    checks++; if (sync_cyc !== cyc) begin errors++; $display("FAIL basic_sync_pos got %0d want %0d", sync_cyc, cyc); end
    s = sync_cyc;
    send_seq(64'hA5, 8, 1'b0);
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", data_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    drive(1'b0, 1'b0);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", data_valid); end
    checks++; if (cyc - s !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", cyc - s); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", data_out); end
    checks++; if (lsb_data_out !== 8'hA5) begin errors++; $display("FAIL basic_lsb_data got %h want a5", lsb_data_out); end
    drive(1'b0, 1'b0);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got %0d want 1", frame_cnt); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun got %b want 0", overrun); end
    checks++; if (sync_cnt !== 1) begin errors++; $display("FAIL basic_no_resync got %0d want 1", sync_cnt); end
  endtask

  task automatic test_bit_order;
    send_frame(8'b11000000);
    checks++; if (data_out !== 8'hC0) begin errors++; $display("FAIL order_msb got %h want c0", data_out); end
    checks++; if (lsb_data_out !== 8'h03) begin errors++; $display("FAIL order_lsb got %h want 03", lsb_data_out); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL order_cnt got %0d want 2", frame_cnt); end
  endtask

  task automatic test_gaps;
    int s;
    sync_cnt = 0; stray = 0;
    send_seq(64'(PAT), 7, 1'b1);
    checks++; if (sync_cnt !== 1) begin errors++; $display("FAIL gap_sync_cnt got %0d want 1", sync_cnt); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL gap_stray got %0d want 0", stray); end
    checks++; if (sync_cyc !== cyc - 1) begin errors++; $display("FAIL gap_sync_pos got %0d want %0d", sync_cyc, cyc - 1); end
    s = sync_cyc;
    send_seq(64'hA5, 8, 1'b1);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", data_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL gap_data got %h want a5", data_out); end
    checks++; if (cyc - s !== 17) begin errors++; $display("FAIL gap_latency got %0d want 17", cyc - s); end
    drive(1'b0, 1'b0);
    checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL gap_cnt got %0d want 3", frame_cnt); end
  endtask

  task automatic test_backpressure;
    logic bp_b [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic bp_v [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    send_seq(64'(PAT), 7, 1'b0);
    send_seq(64'hA5, 8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive4(bp_b[i], bp_v[i], 1'b0, 1'b0);
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got %b want 1", i, data_valid); end
      checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL bp_data_%0d got %h want a5", i, data_out); end
    end
    drive4(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hs got %b want 1", data_valid); end
    drive(1'b0, 1'b0);
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL bp_cnt got %0d want 4", frame_cnt); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", overrun); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", data_valid); end
    drive4(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clr_overrun got %b want 0", overrun); end
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL bp_clr_cnt got %0d want 4", frame_cnt); end
  endtask

  task automatic test_abort_rst;
    send_seq(64'(PAT), 7, 1'b0);
    send_seq(64'b1011, 4, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_busy got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL arst_data got %h want 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy0 got %b want 0", busy); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", frame_cnt); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", data_valid); end
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h3C);
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL arst_recover_data got %h want 3c", data_out); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL arst_recover_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_abort_clr;
    send_seq(64'(PAT), 7, 1'b0);
    send_seq(64'b1010, 4, 1'b0);
    drive4(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %b want 0", data_valid); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL clr_cnt got %0d want 1", frame_cnt); end
    checks++; if (data_out !== 8'hCA) begin errors++; $display("FAIL clr_data_held got %h want ca", data_out); end
    sync_cnt = 0;
    send_seq(64'b011111, 6, 1'b0);
    drive4(1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (sync_cnt !== 0) begin errors++; $display("FAIL clr_sync_mask got %0d want 0", sync_cnt); end
    drive(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_no_collect got %b want 0", busy); end
    send_frame(8'h81);
    checks++; if (data_out !== 8'h81) begin errors++; $display("FAIL clr_recover_data got %h want 81", data_out); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL clr_recover_cnt got %0d want 2", frame_cnt); end
  endtask

  task automatic test_near_miss_wrap;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sync_cnt = 0;
    send_seq(64'b01111110111110, 14, 1'b0);
    checks++; if (sync_cnt !== 1) begin errors++; $display("FAIL near_sync_cnt got %0d want 1", sync_cnt); end
    checks++; if (sync_cyc !== cyc) begin errors++; $display("FAIL near_sync_pos got %0d want %0d", sync_cyc, cyc); end
    send_seq(64'h01, 8, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++; if (c2_frame_cnt !== 2'd1) begin errors++; $display("FAIL wrap_c2_1 got %0d want 1", c2_frame_cnt); end
    send_frame(8'h02);
    send_frame(8'h03);
    checks++; if (c2_frame_cnt !== 2'd3) begin errors++; $display("FAIL wrap_c2_3 got %0d want 3", c2_frame_cnt); end
    send_frame(8'h04);
    checks++; if (c2_frame_cnt !== 2'd0) begin errors++; $display("FAIL wrap_c2_0 got %0d want 0", c2_frame_cnt); end
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL wrap_cnt8 got %0d want 4", frame_cnt); end
    checks++; if (c2_data_out !== 8'h04) begin errors++; $display("FAIL wrap_data got %h want 04", c2_data_out); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bit_order;
    test_gaps;
    test_backpressure;
    test_abort_rst;
    test_abort_clr;
    test_near_miss_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/serial_frame_collector.md
# serial_frame_collector

Parametrised serial frame receiver: hunts a bit stream for a programmable sync pattern, then deserialises a fixed-length payload and presents it on a valid/ready handshake. It sits between the serial line front-end and the parallel consumer, and is the generalised successor of the fixed 7-bit start-sequence detector. It adds configurable pattern and payload widths, overlap-correct pattern matching, a bit-valid qualifier, a bit-order mode, a frame counter and an overrun flag.

## Interface
- PAT_W, 7, sync pattern length in bits; legal range 2..16
- PATTERN, 7'b0111110, sync pattern; PATTERN[PAT_W-1] is the first bit received
- PAYLOAD_W, 8, payload bits per frame; legal range 1..64
- MSB_FIRST, 1, 1: first payload bit lands in data_out[PAYLOAD_W-1]; 0: first payload bit lands in data_out[0]
- CNT_W, 8, frame counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- ser_in  in  1  serial data bit
- in_valid  in  1  ser_in is sampled only on cycles where in_valid=1
- clr  in  1  synchronous abort: return to HUNT and clear overrun
- data_ready  in  1  consumer accepts data_out
- sync_det  out  1  Mealy pulse, high in the cycle the last pattern bit is presented
- data_out  out  PAYLOAD_W  assembled payload, stable while data_valid=1
- data_valid  out  1  payload available
- busy  out  1  high in COLLECT and HOLD
- frame_cnt  out  CNT_W  count of completed handshakes, wraps modulo 2^CNT_W
- overrun  out  1  sticky; a valid bit arrived in HOLD and was dropped

## Operation
- States: HUNT, COLLECT, HOLD. Reset state is HUNT.
- Reset values: hist=0, hist_cnt=0, bit_cnt=0, data_out=0, data_valid=0, busy=0, frame_cnt=0, overrun=0. sync_det is 0 while rst is asserted.
- HUNT:
  - On each valid bit, hist <= {hist[PAT_W-2:0], ser_in}. hist_cnt increments and saturates at PAT_W-1.
  - match = in_valid & (hist_cnt==PAT_W-1) & ({hist[PAT_W-2:0], ser_in}==PATTERN).
  - sync_det = match, combinationally and in HUNT only.
  - On match: go to COLLECT, bit_cnt <= 0.
  - Overlapping patterns are detected correctly because hist keeps shifting. Example: for PATTERN 0101, the stream 0101 01 gives a match at bit 4 only, since collection starts after the first match.
- COLLECT:
  - On each valid bit, shift into data_out toward the LSB if MSB_FIRST=1, or toward the MSB if MSB_FIRST=0. bit_cnt increments.
  - On the valid bit with bit_cnt==PAYLOAD_W-1: go to HOLD and set data_valid <= 1.
  - Cycles with in_valid=0 hold all state.
- HOLD:
  - data_valid=1 and data_out is frozen.
  - When data_ready=1: data_valid <= 0, frame_cnt <= frame_cnt+1, hist_cnt <= 0, go to HUNT.
  - Any in_valid=1 in HOLD sets overrun <= 1 and the bit is discarded. This applies even in the handshake cycle.
- clr: has priority over all non-reset activity. Next state HUNT, hist_cnt=0, bit_cnt=0, data_valid=0, overrun=0. data_out and frame_cnt are held. No handshake occurs in that cycle, even if data_ready=1. sync_det is forced to 0 during clr.
- Reset mid-frame aborts immediately. Partial payload is lost and every output returns to its reset value.

## Timing
- sync_det: zero latency, in the same cycle as the final pattern bit.
- The first payload bit is the first valid bit after the match cycle. A pattern bit is never reused as payload.
- data_valid rises on the clock edge that samples payload bit PAYLOAD_W. With continuous in_valid, that is PAYLOAD_W cycles after the sync_det cycle.
- Handshake completes on the edge where data_valid & data_ready. The next frame's first pattern bit may be sampled on the following cycle. The history is empty at that point, so PAT_W fresh bits are needed before any match.
- Minimum frame period with in_valid=1 continuously and data_ready=1: PAT_W + PAYLOAD_W + 1 cycles.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan
- Defaults, MSB_FIRST=1, stream 1 1 0111110 then 10100101 with in_valid=1 continuously, data_ready=1:
  - sync_det pulses on the 9th bit.
  - data_valid rises 8 cycles later with data_out=8'hA5.
  - frame_cnt=1 one cycle after.
- Same stream with MSB_FIRST=0 -> data_out=8'hA5 bit-reversed, i.e. 8'hA5.
- Same stream with payload 11000000 -> data_out=8'h03.
- Pattern split by gaps: in_valid toggles 1,0,1,0 throughout.
  - sync_det aligns with the valid final pattern bit only.
  - data_out=8'hA5.
  - The frame takes 2x the cycles.
- Backpressure: hold data_ready=0 for 5 cycles after data_valid while driving 3 valid bits.
  - data_out stays 8'hA5 throughout.
  - overrun=1.
  - Handshake on the 6th cycle gives frame_cnt=1.
  - clr then clears overrun to 0 and frame_cnt stays 1.
- Abort paths:
  - rst asserted after 4 payload bits -> all outputs 0 and state HUNT. A following full frame is received correctly.
  - clr after 4 payload bits -> same recovery, but frame_cnt is held.
- Near-miss and counter wrap, with CNT_W=2:
  - Stream 0111111 0111110 + payload -> no sync_det on the first group; detection on the second.
  - 4 frames -> frame_cnt wraps to 0.
